cpu_cmd_arbiter: RTL and testbench
==================================

Name: cpu_cmd_arbiter

Overview:
- Shares one CPU datapath (input muxes, ALU, memory, result register, command register) between NREQ requesters.
- Accepts command plus four operand bytes per requester, grants round-robin, drives the CPU command and data inputs, and tracks cpu_rdy through issue and completion.
- Returns the 16-bit result, zero flag and error flag to the granted requester.
- Sits directly above the CPU top; requesters never drive the CPU themselves.

Parameters:
- WIDTH, 8: operand byte width; result is 2*WIDTH.
- NREQ, 4: number of requesters, 2..8.
- TIMEOUT, 64: cycle limit per wait phase; used only with CPU_ARB_TIMEOUT_EN.
- NOP_CMD, 7'h00: command driven to the CPU when no command is being issued.

Ports:
- clk  input  1  system clock.
- reset  input  1  one clock; reset is asynchronous and active-low.
- req_valid  input  NREQ  request pending, one bit per requester.
- req_ready  output  NREQ  one-hot acceptance pulse.
- req_cmd  input  7*NREQ  flattened commands; requester i uses bits [7i+6:7i].
- req_data  input  4*WIDTH*NREQ  flattened operands din_1..din_4 per requester, din_1 in the low byte.
- cpu_cmd  output  7  command to the CPU cmd_in.
- cpu_din_1..cpu_din_4  output  WIDTH each  operand bytes to the CPU.
- cpu_rdy  input  1  CPU idle/done.
- cpu_result  input  2*WIDTH  CPU out_reg3.
- cpu_zero, cpu_error  input  1 each  CPU flags.
- rsp_valid  output  NREQ  one-hot, one-cycle response strobe.
- rsp_data  output  2*WIDTH  captured result.
- rsp_zero, rsp_error, rsp_timeout  output  1 each  captured flags.
- busy  output  1  high in any state other than IDLE.
- grant_id  output  $clog2(NREQ)  index of the current or last grant.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0, except cpu_cmd=NOP_CMD.
  - Round-robin pointer = 0; holding registers = 0.
- States: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE:
  - If any req_valid=1 and cpu_rdy=1, grant the first valid requester at or after the pointer, wrapping modulo NREQ.
  - Same cycle: req_ready[g]=1; latch req_cmd[g] and req_data[g] into the holding registers; grant_id<=g; pointer<=(g+1) mod NREQ; next state ISSUE.
  - If cpu_rdy=0 or no req_valid: stay in IDLE; no req_ready.
- Requester rule: hold req_valid and payload until req_ready is seen. The arbiter may grant a different requester if req_valid drops.
- ISSUE:
  - cpu_cmd = latched command; cpu_din_* = latched operands.
  - When cpu_rdy=0 (CPU accepted), go to WAIT_DONE.
- WAIT_DONE:
  - cpu_cmd = NOP_CMD; cpu_din_* hold the latched values.
  - When cpu_rdy=1, capture cpu_result, cpu_zero, cpu_error that cycle; rsp_timeout<=0; go to RESP.
- RESP:
  - rsp_valid[grant_id]=1 for exactly one cycle; then IDLE.
  - rsp_* hold their values until the next capture.
- Latency: accept cycle, then at least 1 cycle in ISSUE, then WAIT_DONE, then RESP. Minimum 4 cycles from req_ready to rsp_valid.
- No new grant in RESP. Earliest next req_ready is the cycle after rsp_valid.
- Fairness: after granting g, requester g has lowest priority on the next grant. With all requesters valid, grants go 0,1,2,3,0...
- Operands pass through unchanged; the arbiter does no arithmetic.
- cpu_rdy glitching low in IDLE is ignored; IDLE only checks cpu_rdy for the grant condition.
- Reset mid-operation: transaction dropped; no rsp_valid; cpu_cmd forced to NOP_CMD immediately.

Optional Feature:
- Macro: CPU_ARB_TIMEOUT_EN.
- Defined:
  - Cycle counter clears on entry to ISSUE and to WAIT_DONE, and increments each cycle in those states.
  - If it reaches TIMEOUT-1 without the exit condition, go to RESP with rsp_data=0, rsp_zero=0, rsp_error=1, rsp_timeout=1, and cpu_cmd=NOP_CMD.
  - The pointer has already advanced.
- Not defined: no counter; ISSUE and WAIT_DONE wait indefinitely; rsp_timeout is tied 0.

Test Plan:
- Single request: requester 2, cmd=7'h15, data {04,03,02,01}, cpu model holds rdy=0 for 3 cycles, result 16'h0006, zero=0.
  -> req_ready[2] pulses once; cpu_cmd=7'h15 until rdy falls, then 7'h00; rsp_valid=4'b0100 with rsp_data=16'h0006; busy low afterwards.
- All four valid continuously, 8 transactions -> grant_id sequence 0,1,2,3,0,1,2,3; each rsp_valid one-hot matches its grant.
- cpu_rdy=0 at request time -> no req_ready until cpu_rdy=1; grant occurs in the first cycle both are high.
- cpu model returns error=1, zero=1, result=16'h0000 -> rsp_error=1, rsp_zero=1, rsp_timeout=0.
- With CPU_ARB_TIMEOUT_EN and TIMEOUT=64, cpu_rdy stuck low after accept -> rsp_valid after 64 cycles in WAIT_DONE, rsp_timeout=1, rsp_error=1, rsp_data=0.
- Assert reset=0 during WAIT_DONE -> cpu_cmd=7'h00 and busy=0 without a clock edge; no rsp_valid; after release, next request served starting from pointer 0.

Source files
------------

// File: rtl/cpu_cmd_arbiter_if.sv
// Requester/CPU-facing bus of the command arbiter.
// slave  : arbiter view (takes requests and CPU status, drives CPU inputs and responses).
// master : environment view (requesters plus CPU top).
interface cpu_cmd_arbiter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4
);
    // Requester side
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [7*NREQ-1:0]       req_cmd;
    logic [4*WIDTH*NREQ-1:0] req_data;

    // CPU side
    logic [6:0]              cpu_cmd;
    logic [WIDTH-1:0]        cpu_din_1;
    logic [WIDTH-1:0]        cpu_din_2;
    logic [WIDTH-1:0]        cpu_din_3;
    logic [WIDTH-1:0]        cpu_din_4;
    logic                    cpu_rdy;
    logic [2*WIDTH-1:0]      cpu_result;
    logic                    cpu_zero;
    logic                    cpu_error;

    // Response side
    logic [NREQ-1:0]         rsp_valid;
    logic [2*WIDTH-1:0]      rsp_data;
    logic                    rsp_zero;
    logic                    rsp_error;
    logic                    rsp_timeout;

    modport slave (
        input  req_valid, req_cmd, req_data,
        input  cpu_rdy, cpu_result, cpu_zero, cpu_error,
        output req_ready,
        output cpu_cmd, cpu_din_1, cpu_din_2, cpu_din_3, cpu_din_4,
        output rsp_valid, rsp_data, rsp_zero, rsp_error, rsp_timeout
    );

    modport master (
        output req_valid, req_cmd, req_data,
        output cpu_rdy, cpu_result, cpu_zero, cpu_error,
        input  req_ready,
        input  cpu_cmd, cpu_din_1, cpu_din_2, cpu_din_3, cpu_din_4,
        input  rsp_valid, rsp_data, rsp_zero, rsp_error, rsp_timeout
    );
endinterface

// File: rtl/cpu_cmd_arbiter.sv
// Round-robin arbiter sharing one CPU datapath between NREQ requesters.
// A granted command plus four operand bytes is latched, issued to the CPU until it
// drops cpu_rdy, then the arbiter waits for cpu_rdy to return and hands the result
// and flags back to the granted requester with a one-cycle rsp_valid strobe.
// Optional: define CPU_ARB_TIMEOUT_EN to bound ISSUE and WAIT_DONE by TIMEOUT cycles
// each; an expired wait returns a response flagged with rsp_error and rsp_timeout.
module cpu_cmd_arbiter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter logic [6:0]  NOP_CMD = 7'h00,
    localparam int unsigned IdW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic           clk,
    input  logic           reset,
    cpu_cmd_arbiter_if.slave bus,
    output logic           busy,
    output logic [IdW-1:0] grant_id
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitDone,
        StResp
    } state_e;

    state_e               state_q, state_d;
    logic [IdW-1:0]       ptr_q, ptr_d;
    logic [IdW-1:0]       grant_id_q, grant_id_d;
    logic [6:0]           cmd_q, cmd_d;
    logic [4*WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                 rsp_zero_q, rsp_zero_d;
    logic                 rsp_error_q, rsp_error_d;
    logic                 rsp_timeout_q, rsp_timeout_d;

    logic                 grant_found;
    logic [IdW-1:0]       grant_idx;
    logic [IdW:0]         rr_sum;
    logic [IdW-1:0]       grant_next;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;

`ifdef CPU_ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 cnt_hit;
`else
    // TIMEOUT only matters when the wait-phase counter is built.
    logic                 unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_sum      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            rr_sum = {1'b0, ptr_q} + (IdW+1)'(k);
            if (rr_sum >= (IdW+1)'(NREQ)) begin
                rr_sum = rr_sum - (IdW+1)'(NREQ);
            end
            if (!grant_found && bus.req_valid[rr_sum[IdW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = rr_sum[IdW-1:0];
            end
        end
        grant_next = (grant_idx == IdW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Next-state logic: grant, issue, completion capture and (optionally) timeout.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        cmd_d         = cmd_q;
        opnd_d        = opnd_q;
        rsp_data_d    = rsp_data_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
        req_ready     = '0;
`ifdef CPU_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        cnt_hit       = (cnt_q == CntW'(TIMEOUT - 1));
`endif
        case (state_q)
            StIdle: begin
                // cpu_rdy is only consulted here as part of the grant condition.
                if (grant_found && bus.cpu_rdy) begin
                    req_ready[grant_idx] = 1'b1;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (grant_idx == IdW'(i)) begin
                            cmd_d  = bus.req_cmd[7*i +: 7];
                            opnd_d = bus.req_data[4*WIDTH*i +: 4*WIDTH];
                        end
                    end
                    grant_id_d = grant_idx;
                    ptr_d      = grant_next;
                    state_d    = StIssue;
`ifdef CPU_ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            StIssue: begin
                // CPU takes the command by dropping cpu_rdy.
                if (!bus.cpu_rdy) begin
                    state_d = StWaitDone;
`ifdef CPU_ARB_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (cnt_hit) begin
                    state_d       = StResp;
                    rsp_data_d    = '0;
                    rsp_zero_d    = 1'b0;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StWaitDone: begin
                if (bus.cpu_rdy) begin
                    state_d       = StResp;
                    rsp_data_d    = bus.cpu_result;
                    rsp_zero_d    = bus.cpu_zero;
                    rsp_error_d   = bus.cpu_error;
                    rsp_timeout_d = 1'b0;
`ifdef CPU_ARB_TIMEOUT_EN
                end else if (cnt_hit) begin
                    state_d       = StResp;
                    rsp_data_d    = '0;
                    rsp_zero_d    = 1'b0;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StResp: begin
                // No grant here; the next acceptance is one cycle after the strobe.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and holding registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            grant_id_q    <= '0;
            cmd_q         <= '0;
            opnd_q        <= '0;
            rsp_data_q    <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            cmd_q         <= cmd_d;
            opnd_q        <= opnd_d;
            rsp_data_q    <= rsp_data_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

`ifdef CPU_ARB_TIMEOUT_EN
    // Wait-phase cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // One-hot response strobe towards the granted requester.
    always_comb begin
        rsp_valid = '0;
        if (state_q == StResp) begin
            rsp_valid[grant_id_q] = 1'b1;
        end
    end

    // Command is only presented while issuing, so reset forces NOP without a clock.
    assign bus.cpu_cmd     = (state_q == StIssue) ? cmd_q : NOP_CMD;
    assign bus.cpu_din_1   = opnd_q[0*WIDTH +: WIDTH];
    assign bus.cpu_din_2   = opnd_q[1*WIDTH +: WIDTH];
    assign bus.cpu_din_3   = opnd_q[2*WIDTH +: WIDTH];
    assign bus.cpu_din_4   = opnd_q[3*WIDTH +: WIDTH];
    assign bus.req_ready   = req_ready;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_zero    = rsp_zero_q;
    assign bus.rsp_error   = rsp_error_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign busy            = (state_q != StIdle);
    assign grant_id        = grant_id_q;

endmodule

// File: tb/tb_cpu_cmd_arbiter.sv
// Self-checking bench for cpu_cmd_arbiter: behavioural CPU model plus a response
// scoreboard filled on every observed acceptance and drained on every rsp_valid.
module tb_cpu_cmd_arbiter;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 64;
    localparam logic [6:0]  NOP     = 7'h00;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       busy;
    logic [1:0] grant_id;

    cpu_cmd_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    cpu_cmd_arbiter #(
        .WIDTH   (WIDTH),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT),
        .NOP_CMD (NOP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] data;
        logic        zero;
        logic        error;
        logic        tmo;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    int   grant_log[$];
    int   ready_cnt[NREQ];
    int   rsp_cnt  = 0;

    // CPU model controls
    int          lat      = 3;
    bit          hold_low = 1'b0;
    bit          fixed    = 1'b0;
    bit          exp_tmo  = 1'b0;
    logic [15:0] fix_res  = '0;
    logic        fix_zero = 1'b0;
    logic        fix_err  = 1'b0;
    int          mcnt     = 0;
    logic [15:0] m_res;
    logic        m_zero, m_err;

    exp_t acc_e, rsp_e;
    int   acc_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // CPU model: drops rdy when it sees a command, raises it lat cycles later with a result.
    initial begin
        bus.cpu_rdy    = 1'b1;
        bus.cpu_result = '0;
        bus.cpu_zero   = 1'b0;
        bus.cpu_error  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_low) begin
                bus.cpu_rdy = 1'b0;
            end else if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    bus.cpu_rdy    = 1'b1;
                    bus.cpu_result = m_res;
                    bus.cpu_zero   = m_zero;
                    bus.cpu_error  = m_err;
                end
            end else if (bus.cpu_rdy && bus.cpu_cmd != NOP) begin
                bus.cpu_rdy = 1'b0;
                mcnt        = lat;
                m_res       = fixed ? fix_res : {bus.cpu_din_2, bus.cpu_din_1};
                m_zero      = fixed ? fix_zero : 1'b0;
                m_err       = fixed ? fix_err : 1'b0;
            end else begin
                bus.cpu_rdy = 1'b1;
            end
        end
    end

    // Acceptance monitor: push the expected response.
    always @(negedge clk) begin
        if (reset && |bus.req_ready) begin
            chk("req_ready_onehot", $countones(bus.req_ready), 1);
            acc_id = 0;
            for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) acc_id = i;
            ready_cnt[acc_id]++;
            grant_log.push_back(acc_id);
            acc_e.id = acc_id;
            if (exp_tmo) begin
                acc_e.data = '0; acc_e.zero = 1'b0; acc_e.error = 1'b1; acc_e.tmo = 1'b1;
            end else if (fixed) begin
                acc_e.data = fix_res; acc_e.zero = fix_zero; acc_e.error = fix_err;
                acc_e.tmo  = 1'b0;
            end else begin
                acc_e.data = bus.req_data[32*acc_id +: 16];
                acc_e.zero = 1'b0; acc_e.error = 1'b0; acc_e.tmo = 1'b0;
            end
            sb.push_back(acc_e);
        end
    end

    // Response monitor: pop and compare.
    always @(negedge clk) begin
        if (|bus.rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(bus.rsp_valid), 0);
            end else begin
                rsp_e = sb.pop_front();
                chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << rsp_e.id);
                chk("rsp_data", 32'(bus.rsp_data), 32'(rsp_e.data));
                chk("rsp_zero", 32'(bus.rsp_zero), 32'(rsp_e.zero));
                chk("rsp_error", 32'(bus.rsp_error), 32'(rsp_e.error));
                chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(rsp_e.tmo));
                rsp_cnt++;
            end
        end
    end

    task automatic drive(input int id, input logic [6:0] cmd, input logic [31:0] data);
        bus.req_valid[id]          = 1'b1;
        bus.req_cmd[7*id +: 7]     = cmd;
        bus.req_data[32*id +: 32]  = data;
    endtask

    // Wait for req_ready[id]; returns just after the accepting edge.
    task automatic wait_ready(input int id, input int max);
        bit ok = 1'b0;
        for (int n = 0; n < max && !ok; n++) begin
            @(negedge clk);
            if (bus.req_ready[id]) ok = 1'b1;
        end
        chk("ready_seen", 32'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    // Wait until all expected responses arrived and both DUT and model are idle.
    task automatic wait_drain(input int max);
        bit ok = 1'b0;
        for (int n = 0; n < max && !ok; n++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !busy && bus.cpu_rdy && mcnt == 0) ok = 1'b1;
        end
        chk("drain", 32'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int base;
        bit seen;
        bus.req_valid = '0;
        bus.req_cmd   = '0;
        bus.req_data  = '0;
        for (int i = 0; i < NREQ; i++) ready_cnt[i] = 0;

        // Reset state, checked before any clock edge.
        #2 reset = 1'b0;
        #1;
        chk("rst_cpu_cmd", 32'(bus.cpu_cmd), 32'(NOP));
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 0);
        chk("rst_rsp_flags", {29'd0, bus.rsp_zero, bus.rsp_error, bus.rsp_timeout}, 0);
        chk("rst_cpu_din", {bus.cpu_din_4, bus.cpu_din_3, bus.cpu_din_2, bus.cpu_din_1}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // All four valid continuously: grants rotate 0,1,2,3,0,...
        fixed = 1'b0;
        for (int i = 0; i < NREQ; i++) drive(i, 7'h10 + 7'(i), {16'hC0DE, 8'(i), 8'(3*i + 1)});
        n = 0;
        for (int c = 0; c < 400 && n < 8; c++) begin
            @(negedge clk);
            if (|bus.req_ready) n++;
        end
        @(posedge clk);
        #1 bus.req_valid = '0;
        chk("rr_count", n, 8);
        wait_drain(100);
        chk("rr_log_size", grant_log.size(), 8);
        for (int k = 0; k < grant_log.size(); k++) chk("rr_order", grant_log[k], k % 4);
        chk("rr_rsp_count", rsp_cnt, 8);

        // Single request from requester 2 with a 3-cycle CPU busy period.
        fixed = 1'b1; fix_res = 16'h0006; fix_zero = 1'b0; fix_err = 1'b0;
        base = ready_cnt[2];
        n    = rsp_cnt;
        drive(2, 7'h15, 32'h04030201);
        wait_ready(2, 20);
        bus.req_valid[2] = 1'b0;
        @(negedge clk);
        chk("issue_cmd", 32'(bus.cpu_cmd), 32'h15);
        chk("issue_din_1", 32'(bus.cpu_din_1), 32'h01);
        chk("issue_din_4", 32'(bus.cpu_din_4), 32'h04);
        chk("issue_busy", 32'(busy), 1);
        chk("issue_grant_id", 32'(grant_id), 2);
        @(negedge clk);
        chk("wait_cmd_nop", 32'(bus.cpu_cmd), 32'(NOP));
        chk("wait_din_2", 32'(bus.cpu_din_2), 32'h02);
        wait_drain(50);
        chk("single_ready_once", ready_cnt[2] - base, 1);
        chk("single_rsp", rsp_cnt - n, 1);
        chk("single_busy_after", 32'(busy), 0);

        // cpu_rdy low at request time: no grant until rdy returns.
        fixed    = 1'b0;
        hold_low = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        drive(1, 7'h21, 32'h0000BEEF);
        repeat (4) begin
            @(negedge clk);
            chk("no_ready_rdy_low", 32'(bus.req_ready), 0);
        end
        @(posedge clk);
        #1 hold_low = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.cpu_rdy) begin
                seen = 1'b1;
                chk("grant_first_rdy", 32'(bus.req_ready), 32'b0010);
            end else begin
                chk("no_ready_rdy_low", 32'(bus.req_ready), 0);
            end
        end
        chk("rdy_returned", 32'(seen), 1);
        @(posedge clk);
        #1 bus.req_valid[1] = 1'b0;
        wait_drain(50);

        // CPU returns error and zero with a zero result.
        fixed = 1'b1; fix_res = 16'h0000; fix_zero = 1'b1; fix_err = 1'b1;
        drive(3, 7'h2A, 32'hFFFF0000);
        wait_ready(3, 20);
        bus.req_valid[3] = 1'b0;
        wait_drain(50);
        chk("err_hold_error", 32'(bus.rsp_error), 1);
        chk("err_hold_zero", 32'(bus.rsp_zero), 1);
        chk("err_hold_timeout", 32'(bus.rsp_timeout), 0);
        fixed = 1'b0;

`ifdef CPU_ARB_TIMEOUT_EN
        // CPU stays busy far beyond TIMEOUT after accepting the command.
        exp_tmo = 1'b1;
        lat     = 200;
        n       = rsp_cnt;
        drive(0, 7'h05, 32'h12345678);
        wait_ready(0, 20);
        bus.req_valid[0] = 1'b0;
        base = 0;
        for (int c = 0; c < 200 && rsp_cnt == n; c++) begin
            @(negedge clk);
            base++;
            #1;
        end
        chk("timeout_latency", base, 66);
        exp_tmo = 1'b0;
        lat     = 3;
        wait_drain(400);
`endif

        // Reset during WAIT_DONE drops the transaction and clears the pointer.
        drive(1, 7'h33, 32'h11223344);
        wait_ready(1, 20);
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_cpu_cmd", 32'(bus.cpu_cmd), 32'(NOP));
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_grant_id", 32'(grant_id), 0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        wait_drain(20);
        drive(0, 7'h41, 32'h0000A5A5);
        drive(2, 7'h42, 32'h00005A5A);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (|bus.req_ready) begin
                seen = 1'b1;
                chk("post_rst_grant0", 32'(bus.req_ready), 32'b0001);
            end
        end
        chk("post_rst_ready_seen", 32'(seen), 1);
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
